// File: rtl/oled_spi_ctrl_pkg.sv
// Shared definitions for the OLED SPI controller: FSM state encoding,
// default parameter values and a counter-width helper.
package oled_spi_ctrl_pkg;

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      VDD_ON   = 3'd1,
      RST_LOW  = 3'd2,
      RST_HIGH = 3'd3,
      VBAT_ON  = 3'd4,
      READY    = 3'd5,
      SHIFT    = 3'd6,
      VBAT_OFF = 3'd7
   } state_t;

   localparam int unsigned DEF_WIDTH        = 8;
   localparam int unsigned DEF_CLK_DIV      = 4;
   localparam int unsigned DEF_POWER_DELAY  = 1000;
   localparam int unsigned DEF_RESET_CYCLES = 100;

   // Bits needed for a counter running 0 .. max_count-1 (never less than 1).
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI mode-3 word shifter: SCLK generation and MSB-first bit output.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   start         - load data and begin a word (ignored while busy)
//   data          - word to shift
//   sclk          - serial clock, idles high
//   dout          - current bit; holds the last bit between words
//   done          - high during the final cycle of a word
module oled_spi_shifter
   import oled_spi_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             sclk,
   output logic             dout,
   output logic             done
);

   localparam int unsigned DIV_W = cnt_width(CLK_DIV);
   localparam int unsigned BIT_W = cnt_width(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             high_phase;
   logic             busy;
   logic             div_end;

   assign div_end = (div_cnt == DIV_LAST);
   assign done    = busy && high_phase && div_end && (bit_cnt == BIT_LAST);
   // The register is only shifted on a bit advance, so its MSB is the
   // current bit and keeps the last bit once the word finishes.
   assign dout    = shreg[WIDTH-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         high_phase <= 1'b0;
         busy       <= 1'b0;
         sclk       <= 1'b1;
      end else if (start && !busy) begin
         shreg      <= data;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         high_phase <= 1'b0;
         busy       <= 1'b1;
         sclk       <= 1'b0;
      end else if (busy) begin
         if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            if (!high_phase) begin
               high_phase <= 1'b1;
               sclk       <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
               busy <= 1'b0;
            end else begin
               bit_cnt    <= bit_cnt + 1'b1;
               high_phase <= 1'b0;
               sclk       <= 1'b0;
               shreg      <= shreg << 1;
            end
         end
      end
   end

endmodule

// File: rtl/oled_spi_ctrl.sv
// OLED panel controller: power/reset sequencing plus a word interface that
// serialises command/data words over SPI mode 3.
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   in_enable               - 1 requests power-up, 0 power-down
//   in_valid/in_ready       - word handshake
//   in_data, in_isData      - word (MSB first) and D/C flag
//   out_oled_vdd/vbat       - supply enables, active-low
//   out_oled_reset          - panel reset, active-low
//   out_oled_clk/dout       - SCLK and MOSI
//   out_oled_isData         - D/C line, held from the last accepted word
//   out_oled_debug          - 1 while a word is shifting
//   out_powered             - 1 in READY or SHIFT
module oled_spi_ctrl
   import oled_spi_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH        = DEF_WIDTH,
   parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
   parameter int unsigned POWER_DELAY  = DEF_POWER_DELAY,
   parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_isData,
   output logic             out_oled_vdd,
   output logic             out_oled_vbat,
   output logic             out_oled_reset,
   output logic             out_oled_clk,
   output logic             out_oled_dout,
   output logic             out_oled_isData,
   output logic             out_oled_debug,
   output logic             out_powered
);

   localparam int unsigned DLY_MAX = (POWER_DELAY > RESET_CYCLES) ? POWER_DELAY : RESET_CYCLES;
   localparam int unsigned DLY_W   = cnt_width(DLY_MAX);
   localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(POWER_DELAY - 1);
   localparam logic [DLY_W-1:0] RST_LAST = DLY_W'(RESET_CYCLES - 1);

   state_t           state, state_next;
   logic [DLY_W-1:0] cnt, cnt_next;
   logic             off_req, off_req_next;
   logic             panel_rst;
   logic             is_data;
   logic             accept;
   logic             sh_done;

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      off_req_next = off_req;
      accept       = 1'b0;
      case (state)
         OFF: begin
            if (in_enable) begin
               state_next = VDD_ON;
               cnt_next   = '0;
            end
         end
         VDD_ON, RST_LOW, RST_HIGH, VBAT_ON: begin
            if (!in_enable) begin
               state_next = VBAT_OFF;
               cnt_next   = '0;
            end else if (cnt == (((state == RST_LOW) || (state == RST_HIGH)) ? RST_LAST : PWR_LAST)) begin
               cnt_next = '0;
               case (state)
                  VDD_ON:   state_next = RST_LOW;
                  RST_LOW:  state_next = RST_HIGH;
                  RST_HIGH: state_next = VBAT_ON;
                  default:  state_next = READY;
               endcase
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         READY: begin
            if (!in_enable) begin
               state_next = VBAT_OFF;
               cnt_next   = '0;
            end else if (in_valid) begin
               accept       = 1'b1;
               state_next   = SHIFT;
               off_req_next = 1'b0;
            end
         end
         SHIFT: begin
            // A power-down request seen at any point of the word is
            // remembered so the word still finishes before power-down.
            if (!in_enable) off_req_next = 1'b1;
            if (sh_done) begin
               cnt_next     = '0;
               off_req_next = 1'b0;
               state_next   = (off_req || !in_enable) ? VBAT_OFF : READY;
            end
         end
         VBAT_OFF: begin
            if (cnt == PWR_LAST) begin
               state_next = OFF;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = OFF;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= OFF;
         cnt       <= '0;
         off_req   <= 1'b0;
         panel_rst <= 1'b0;
         is_data   <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         off_req <= off_req_next;
         // Panel reset is released in RST_HIGH and stays as it was while
         // VBAT ramps down, so an early abort never pulses it high.
         panel_rst <= (state_next inside {RST_HIGH, VBAT_ON, READY, SHIFT}) ||
                      ((state_next == VBAT_OFF) && panel_rst);
         if (accept) is_data <= in_isData;
      end
   end

   oled_spi_shifter #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clock (clock),
      .reset (reset),
      .start (accept),
      .data  (in_data),
      .sclk  (out_oled_clk),
      .dout  (out_oled_dout),
      .done  (sh_done)
   );

   assign in_ready        = (state == READY) && in_enable;
   assign out_oled_vdd    = (state == OFF);
   assign out_oled_vbat   = !(state inside {VBAT_ON, READY, SHIFT});
   assign out_oled_reset  = panel_rst;
   assign out_oled_isData = is_data;
   assign out_oled_debug  = (state == SHIFT);
   assign out_powered     = (state == READY) || (state == SHIFT);

endmodule

// File: tb/tb_oled_spi_ctrl.sv
module tb_oled_spi_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned CD = 2;
   localparam int unsigned PD = 20;
   localparam int unsigned RC = 5;

   localparam int S_VDD = 0, S_VBAT = 1, S_RST = 2, S_POW = 3, S_RDY = 4, S_DBG = 5;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         in_enable = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_isData = 1'b0;
   logic         out_oled_vdd, out_oled_vbat, out_oled_reset, out_oled_clk;
   logic         out_oled_dout, out_oled_isData, out_oled_debug, out_powered;

   int checks = 0;
   int failures = 0;

   logic [63:0] cap_all = '0;
   int          cap_total = 0;

   oled_spi_ctrl #(
      .WIDTH        (W),
      .CLK_DIV      (CD),
      .POWER_DELAY  (PD),
      .RESET_CYCLES (RC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .in_enable       (in_enable),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_isData       (in_isData),
      .out_oled_vdd    (out_oled_vdd),
      .out_oled_vbat   (out_oled_vbat),
      .out_oled_reset  (out_oled_reset),
      .out_oled_clk    (out_oled_clk),
      .out_oled_dout   (out_oled_dout),
      .out_oled_isData (out_oled_isData),
      .out_oled_debug  (out_oled_debug),
      .out_powered     (out_powered)
   );

   always #5 clock = ~clock;

   // Panel-side view: MOSI sampled on each rising SCLK edge.
   always @(posedge out_oled_clk) begin
      cap_all   = {cap_all[62:0], out_oled_dout};
      cap_total = cap_total + 1;
   end

   function automatic logic sig(input int sel);
      case (sel)
         S_VDD:   return out_oled_vdd;
         S_VBAT:  return out_oled_vbat;
         S_RST:   return out_oled_reset;
         S_POW:   return out_powered;
         S_RDY:   return in_ready;
         default: return out_oled_debug;
      endcase
   endfunction

   task automatic count_edges(input int sel, input logic val, input int maxc, output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (sig(sel) !== val && n < maxc);
   endtask

   function automatic logic [8:0] out_vec();
      return {out_oled_vdd, out_oled_vbat, out_oled_reset, out_oled_clk, out_oled_dout,
              out_oled_isData, in_ready, out_oled_debug, out_powered};
   endfunction

   task automatic test_reset();
      logic [8:0] v;
      reset = 1'b0;
      #12;
      v = out_vec();
      checks++;
      if (v !== 9'b110100000) begin failures++; $display("FAIL reset_outputs: got %b expected %b", v, 9'b110100000); end
      @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (out_oled_vdd !== 1'b1) begin failures++; $display("FAIL stay_off_vdd: got %b expected 1", out_oled_vdd); end
      checks++;
      if (out_oled_reset !== 1'b0) begin failures++; $display("FAIL stay_off_reset: got %b expected 0", out_oled_reset); end
   endtask

   task automatic test_power_up();
      int n;
      @(negedge clock);
      in_enable = 1'b1;
      count_edges(S_VDD, 1'b0, 10, n);
      checks++;
      if (n !== 1) begin failures++; $display("FAIL vdd_fall_delay: got %0d expected 1", n); end
      count_edges(S_RST, 1'b1, 60, n);
      checks++;
      if (n !== 25) begin failures++; $display("FAIL reset_rise_delay: got %0d expected 25", n); end
      count_edges(S_VBAT, 1'b0, 30, n);
      checks++;
      if (n !== 5) begin failures++; $display("FAIL vbat_fall_delay: got %0d expected 5", n); end
      count_edges(S_POW, 1'b1, 40, n);
      checks++;
      if (n !== 20) begin failures++; $display("FAIL powered_delay: got %0d expected 20", n); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_powerup: got %b expected 1", in_ready); end
   endtask

   task automatic test_command();
      int n, start;
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'hA5; in_isData = 1'b0;
      start = cap_total;
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if (out_oled_debug !== 1'b1) begin failures++; $display("FAIL cmd_debug: got %b expected 1", out_oled_debug); end
      count_edges(S_RDY, 1'b1, 100, n);
      checks++;
      if (n !== 32) begin failures++; $display("FAIL cmd_ready_low: got %0d expected 32", n); end
      checks++;
      if ((cap_total - start) !== 8) begin failures++; $display("FAIL cmd_bit_count: got %0d expected 8", cap_total - start); end
      checks++;
      if (cap_all[7:0] !== 8'hA5) begin failures++; $display("FAIL cmd_bits: got %h expected a5", cap_all[7:0]); end
      checks++;
      if (out_oled_isData !== 1'b0) begin failures++; $display("FAIL cmd_isdata: got %b expected 0", out_oled_isData); end
      checks++;
      if (out_oled_dout !== 1'b1) begin failures++; $display("FAIL cmd_dout_hold: got %b expected 1", out_oled_dout); end
      checks++;
      if (out_oled_clk !== 1'b1) begin failures++; $display("FAIL cmd_clk_idle: got %b expected 1", out_oled_clk); end
   endtask

   task automatic test_back_to_back();
      int n, start;
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'h3C; in_isData = 1'b1;
      start = cap_total;
      @(posedge clock); #1;
      checks++;
      if (out_oled_isData !== 1'b1) begin failures++; $display("FAIL b2b_isdata_first: got %b expected 1", out_oled_isData); end
      in_data = 8'hFF; in_isData = 1'b0;
      count_edges(S_RDY, 1'b1, 100, n);
      checks++;
      if (n !== 32) begin failures++; $display("FAIL b2b_first_len: got %0d expected 32", n); end
      checks++;
      if (cap_all[7:0] !== 8'h3C || (cap_total - start) !== 8) begin
         failures++; $display("FAIL b2b_first_bits: got %h/%0d expected 3c/8", cap_all[7:0], cap_total - start);
      end
      checks++;
      if ({out_oled_clk, out_oled_debug, out_oled_isData} !== 3'b101) begin
         failures++; $display("FAIL b2b_idle_cycle: got clk/dbg/isd %b expected 101", {out_oled_clk, out_oled_debug, out_oled_isData});
      end
      start = cap_total;
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_oled_clk, out_oled_debug, out_oled_isData} !== 3'b010) begin
         failures++; $display("FAIL b2b_second_start: got clk/dbg/isd %b expected 010", {out_oled_clk, out_oled_debug, out_oled_isData});
      end
      count_edges(S_RDY, 1'b1, 100, n);
      checks++;
      if (n !== 32) begin failures++; $display("FAIL b2b_second_len: got %0d expected 32", n); end
      checks++;
      if (cap_all[7:0] !== 8'hFF || (cap_total - start) !== 8) begin
         failures++; $display("FAIL b2b_second_bits: got %h/%0d expected ff/8", cap_all[7:0], cap_total - start);
      end
   endtask

   task automatic test_power_down();
      int n, start;
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'h81; in_isData = 1'b1;
      start = cap_total;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clock);
      #1;
      in_enable = 1'b0;
      count_edges(S_DBG, 1'b0, 100, n);
      checks++;
      if (n !== 20) begin failures++; $display("FAIL pd_word_finish: got %0d expected 20", n); end
      checks++;
      if (cap_all[7:0] !== 8'h81 || (cap_total - start) !== 8) begin
         failures++; $display("FAIL pd_bits: got %h/%0d expected 81/8", cap_all[7:0], cap_total - start);
      end
      checks++;
      if ({out_oled_vbat, out_oled_vdd, out_powered, in_ready} !== 4'b1000) begin
         failures++; $display("FAIL pd_vbat_off: got vbat/vdd/pow/rdy %b expected 1000", {out_oled_vbat, out_oled_vdd, out_powered, in_ready});
      end
      count_edges(S_VDD, 1'b1, 40, n);
      checks++;
      if (n !== 20) begin failures++; $display("FAIL pd_off_delay: got %0d expected 20", n); end
      checks++;
      if ({out_oled_reset, out_oled_vbat} !== 2'b01) begin
         failures++; $display("FAIL pd_off_state: got reset/vbat %b expected 01", {out_oled_reset, out_oled_vbat});
      end
   endtask

   task automatic test_async_reset();
      int n, start;
      logic [8:0] v;
      @(negedge clock);
      in_enable = 1'b1;
      count_edges(S_POW, 1'b1, 100, n);
      checks++;
      if (n !== 51) begin failures++; $display("FAIL ar_powerup: got %0d expected 51", n); end
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'hF0; in_isData = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      v = out_vec();
      checks++;
      if (v !== 9'b110100000) begin failures++; $display("FAIL ar_midword_outputs: got %b expected %b", v, 9'b110100000); end
      in_valid = 1'b1; in_data = 8'h5A; in_isData = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      start = cap_total;
      count_edges(S_DBG, 1'b1, 100, n);
      checks++;
      if (n !== 52) begin failures++; $display("FAIL ar_pending_accept: got %0d expected 52", n); end
      in_valid = 1'b0;
      count_edges(S_RDY, 1'b1, 100, n);
      checks++;
      if (n !== 32) begin failures++; $display("FAIL ar_word_len: got %0d expected 32", n); end
      checks++;
      if (cap_all[7:0] !== 8'h5A || (cap_total - start) !== 8) begin
         failures++; $display("FAIL ar_word_bits: got %h/%0d expected 5a/8", cap_all[7:0], cap_total - start);
      end
      checks++;
      if (out_oled_isData !== 1'b0) begin failures++; $display("FAIL ar_isdata: got %b expected 0", out_oled_isData); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_command();
      test_back_to_back();
      test_power_down();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/oled_spi_ctrl.md
OLED_SPI_CTRL -- requirements
Module: oled_spi_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per serial word.
REQ-002 SHALL have parameter CLK_DIV, default 4: clock cycles per SCLK half-period, at least 1.
REQ-003 SHALL have parameter POWER_DELAY, default 1000: cycles waited after each supply change, at least 1.
REQ-004 SHALL have parameter RESET_CYCLES, default 100: cycles for each reset phase, at least 1.
REQ-005 SHALL have the following ports, clock and reset first:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_enable  in  1  level; 1 requests panel power-up, 0 requests power-down.
- in_valid  in  1  word offered.
- in_ready  out  1  word accepted when in_valid and in_ready are both 1.
- in_data  in  WIDTH  word to send, MSB first.
- in_isData  in  1  1 for data, 0 for command.
- out_oled_vdd  out  1  logic supply enable, active-low.
- out_oled_vbat  out  1  panel supply enable, active-low.
- out_oled_reset  out  1  panel reset, active-low.
- out_oled_clk  out  1  SCLK; idles high (SPI mode 3).
- out_oled_dout  out  1  MOSI.
- out_oled_isData  out  1  D/C line.
- out_oled_debug  out  1  1 while a word is shifting.
- out_powered  out  1  1 only in READY or SHIFT.

Function
REQ-006 SHALL use states OFF, VDD_ON, RST_LOW, RST_HIGH, VBAT_ON, READY, SHIFT, VBAT_OFF.
REQ-007 In OFF: vdd=1, vbat=1, reset=0; in_enable=1 moves to VDD_ON on the next cycle.
REQ-008 Power-up sequence:
- VDD_ON drives vdd=0 for POWER_DELAY cycles, then RST_LOW.
- RST_LOW holds reset=0 for RESET_CYCLES cycles, then RST_HIGH.
- RST_HIGH drives reset=1 for RESET_CYCLES cycles, then VBAT_ON.
- VBAT_ON drives vbat=0 for POWER_DELAY cycles, then READY.
REQ-009 in_enable=0 in any of VDD_ON, RST_LOW, RST_HIGH, VBAT_ON or READY SHALL move to VBAT_OFF on the next cycle.
REQ-010 VBAT_OFF drives vbat=1 for POWER_DELAY cycles, then moves to OFF, where vdd=1 and reset=0.
REQ-011 in_enable=0 during SHIFT SHALL let the current word complete, then move to VBAT_OFF instead of READY.
REQ-012 in_ready SHALL be 1 only in READY with in_enable=1; words offered in any other state are neither accepted nor lost, and in_valid stays pending.
REQ-013 On acceptance:
- in_data is latched into a shift register.
- in_isData is latched into out_oled_isData, which holds until the next acceptance.
- The state moves to SHIFT.
REQ-014 Per bit in SHIFT, MSB first:
- clk=0 and dout=the current bit for CLK_DIV cycles.
- Then clk=1 for CLK_DIV cycles.
- The panel samples on the rising edge.
REQ-015 A word SHALL occupy exactly 2*CLK_DIV*WIDTH cycles in SHIFT; in_ready returns to 1 on the following cycle.
REQ-016 Back-to-back words therefore have one idle cycle with clk=1 between them.
REQ-017 out_oled_debug SHALL equal 1 exactly while in SHIFT.
REQ-018 dout SHALL hold its last bit value outside SHIFT.
REQ-019 Delay and bit counters SHALL be sized with $clog2 of their maximum count; no counter may wrap within a phase.

Reset
REQ-020 reset=0 SHALL immediately force all of the following, regardless of state (including mid-word):
- state OFF
- out_oled_vdd=1, out_oled_vbat=1, out_oled_reset=0
- out_oled_clk=1, out_oled_dout=0, out_oled_isData=0
- in_ready=0, out_oled_debug=0, out_powered=0
- all counters cleared
REQ-021 After reset deasserts, the sequence SHALL begin only from OFF, according to in_enable.

Structure
REQ-022 A shared package SHALL hold the state enum type and the default parameter constants.
REQ-023 SCLK generation and bit shifting SHALL live in one sub-module, oled_spi_shifter, with start/done handshake and parameters WIDTH and CLK_DIV; power sequencing stays in oled_spi_ctrl.

Verification (WIDTH=8, CLK_DIV=2, POWER_DELAY=20, RESET_CYCLES=5)
REQ-024 Power-up: raise in_enable after reset.
- vdd falls one cycle later.
- reset rises 25 cycles after vdd falls.
- vbat falls 5 cycles after that.
- out_powered=1 20 cycles after that.
REQ-025 Command word: send 0xA5, in_isData=0.
- Rising SCLK edges sample 1,0,1,0,0,1,0,1.
- isData=0 throughout.
- in_ready is low for 32 cycles.
REQ-026 Back-to-back: send 0x3C (data), then 0xFF (command) with in_valid held.
- Exactly one idle cycle with clk=1 between the words.
- isData switches from 1 to 0 at the second acceptance.
REQ-027 Power-down mid-word: drop in_enable at bit 3 of 0x81.
- All 8 bits complete.
- vbat rises, then OFF is reached 20 cycles later with vdd=1, reset=0.
REQ-028 Async reset mid-word: assert reset between clock edges.
- All outputs reach reset values before the next clock edge.
- An in_valid held during power-up is accepted only after out_powered=1.
